// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment patterns, FSM states and pattern decoder for the frame decoder
package seg7_pkg;

  // Active-low 7-bit patterns, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {SCAN, EMIT} state_t;

  // Returns {hit, nibble}; nibble is 0 when the pattern is not a hex glyph
  function automatic logic [4:0] seg_to_nibble(input logic [6:0] pattern);
    logic [4:0] r;
    r = 5'h00;
    case (pattern)
      SEG_0: r = {1'b1, 4'h0};
      SEG_1: r = {1'b1, 4'h1};
      SEG_2: r = {1'b1, 4'h2};
      SEG_3: r = {1'b1, 4'h3};
      SEG_4: r = {1'b1, 4'h4};
      SEG_5: r = {1'b1, 4'h5};
      SEG_6: r = {1'b1, 4'h6};
      SEG_7: r = {1'b1, 4'h7};
      SEG_8: r = {1'b1, 4'h8};
      SEG_9: r = {1'b1, 4'h9};
      SEG_A: r = {1'b1, 4'hA};
      SEG_B: r = {1'b1, 4'hB};
      SEG_C: r = {1'b1, 4'hC};
      SEG_D: r = {1'b1, 4'hD};
      SEG_E: r = {1'b1, 4'hE};
      SEG_F: r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_frame_decoder_if.sv
// rtl/seg7_frame_decoder_if.sv - scan inputs and frame outputs of the seven-segment frame decoder
interface seg7_frame_decoder_if;
  logic [3:0]  anodes;
  logic [7:0]  cathods;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  frame_count;

  modport master (output anodes, cathods, input value, frame_valid, frame_err, frame_count);
  modport slave  (input anodes, cathods, output value, frame_valid, frame_err, frame_count);
endinterface

// File: rtl/seg7_stable_filter.sv
// rtl/seg7_stable_filter.sv - input register, stability counter and one-shot capture strobe
module seg7_stable_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       clk1,
  input  logic       rst,
  input  logic [3:0] anodes,
  input  logic [7:0] cathods,
  output logic [3:0] anod_q,
  output logic [6:0] cath_seg,
  output logic       capture
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] HIT = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]       cath_q;
  logic [11:0]      prev_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             same;

  // dp takes part in the stability compare but is not decoded
  assign same     = ({anod_q, cath_q} == prev_q);
  assign cath_seg = cath_q[6:0];

  always_comb begin
    count_nxt = '0;
    if (same)
      count_nxt = (count == SAT) ? SAT : count + CNT_W'(1);
  end

  // Fires while the registered pattern is still the one that became stable
  assign capture = (count_nxt == HIT) && (count != HIT);

  always_ff @(posedge clk1) begin
    if (rst) begin
      anod_q <= 4'hF;
      cath_q <= 8'hFF;
      prev_q <= 12'hFFF;
      count  <= '0;
    end else begin
      anod_q <= anodes;
      cath_q <= cathods;
      prev_q <= {anod_q, cath_q};
      count  <= count_nxt;
    end
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// rtl/seg7_frame_decoder.sv - rebuilds the 4-digit hex value from a multiplexed seven-segment scan
// Optional: SEG7_CHANGE_ONLY_EN pulses frame_valid only for changed, erroneous or first frames.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                 clk1,
  input  logic                 rst,
  seg7_frame_decoder_if.slave  bus
);

  state_t           state, state_nxt;
  logic [3:0]       anod_q;
  logic [6:0]       cath_seg;
  logic             capture;
  logic [4:0]       dec;
  logic [1:0]       dig_idx;
  logic             dig_ok;
  logic [3:0][3:0]  digits, digits_nxt;
  logic [3:0]       seen, seen_nxt;
  logic             acc, acc_nxt;
  logic [15:0]      value_r, value_nxt;
  logic             err_r, err_nxt;
  logic             valid_r, valid_nxt;
  logic [7:0]       count_r, count_nxt;
  logic             pulse;

  seg7_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_filter (
    .clk1     (clk1),
    .rst      (rst),
    .anodes   (bus.anodes),
    .cathods  (bus.cathods),
    .anod_q   (anod_q),
    .cath_seg (cath_seg),
    .capture  (capture)
  );

  always_comb begin
    dig_ok  = 1'b1;
    dig_idx = 2'd0;
    case (anod_q)
      4'hE: dig_idx = 2'd0;
      4'hD: dig_idx = 2'd1;
      4'hB: dig_idx = 2'd2;
      4'h7: dig_idx = 2'd3;
      default: dig_ok = 1'b0;
    endcase
  end

`ifdef SEG7_CHANGE_ONLY_EN
  logic first_r;
  assign pulse = (digits != value_r) || acc || first_r;

  always_ff @(posedge clk1) begin
    if (rst)
      first_r <= 1'b1;
    else if (state == EMIT)
      first_r <= 1'b0;
  end
`else
  assign pulse = 1'b1;
`endif

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    seen_nxt   = seen;
    acc_nxt    = acc;
    value_nxt  = value_r;
    err_nxt    = err_r;
    valid_nxt  = 1'b0;
    count_nxt  = count_r;
    dec        = seg_to_nibble(cath_seg);

    if (state == EMIT) begin
      value_nxt = digits;
      err_nxt   = acc;
      seen_nxt  = 4'h0;
      acc_nxt   = 1'b0;
      state_nxt = SCAN;
      if (pulse) begin
        valid_nxt = 1'b1;
        count_nxt = count_r + 8'd1;
      end
    end

    // Applied after the EMIT clear so a coincident capture belongs to the next frame
    if (capture && dig_ok) begin
      digits_nxt[dig_idx] = dec[4] ? dec[3:0] : 4'h0;
      seen_nxt[dig_idx]   = 1'b1;
      if (!dec[4])
        acc_nxt = 1'b1;
    end

    if (state == SCAN && seen_nxt == 4'hF)
      state_nxt = EMIT;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state   <= SCAN;
      digits  <= '0;
      seen    <= 4'h0;
      acc     <= 1'b0;
      value_r <= 16'h0000;
      err_r   <= 1'b0;
      valid_r <= 1'b0;
      count_r <= 8'h00;
    end else begin
      state   <= state_nxt;
      digits  <= digits_nxt;
      seen    <= seen_nxt;
      acc     <= acc_nxt;
      value_r <= value_nxt;
      err_r   <= err_nxt;
      valid_r <= valid_nxt;
      count_r <= count_nxt;
    end
  end

  assign bus.value       = value_r;
  assign bus.frame_err   = err_r;
  assign bus.frame_valid = valid_r;
  assign bus.frame_count = count_r;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// tb/tb_seg7_frame_decoder.sv - scoreboard bench for seg7_frame_decoder
module tb_seg7_frame_decoder;

  typedef struct packed {
    logic [15:0] v;
    logic        e;
    logic [7:0]  c;
  } exp_t;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;

  seg7_frame_decoder_if bus();

  seg7_frame_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_push   = 0;
  int          n_pulse  = 0;
  logic [15:0] m_held   = 16'h0000;
  bit          m_first  = 1'b1;
  logic [7:0]  m_count  = 8'h00;

  // Active-low cathode bytes, dp off
  logic [7:0] seg_tb [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] v, input logic e);
    bit pulse;
    pulse = 1'b1;
`ifdef SEG7_CHANGE_ONLY_EN
    pulse = (v != m_held) || e || m_first;
`endif
    m_held  = v;
    m_first = 1'b0;
    if (pulse) begin
      m_count = m_count + 8'd1;
      q.push_back('{v: v, e: e, c: m_count});
      n_push++;
    end
  endtask

  task automatic drive_raw(input logic [3:0] an, input logic [7:0] cath, input int hold);
    @(negedge clk1);
    bus.anodes  = an;
    bus.cathods = cath;
    repeat (hold) @(posedge clk1);
  endtask

  task automatic show(input int idx, input logic [7:0] cath, input int hold);
    logic [3:0] an;
    an = ~(4'b0001 << idx);
    drive_raw(an, cath, hold);
  endtask

  task automatic scan(input logic [15:0] v, input int hold);
    for (int i = 0; i < 4; i++)
      show(i, seg_tb[v[i*4 +: 4]], hold);
  endtask

  task automatic idle(input int n);
    drive_raw(4'hF, 8'hFF, n);
  endtask

  task automatic pulse_reset();
    @(negedge clk1);
    rst = 1'b1;
    @(negedge clk1);
    rst     = 1'b0;
    m_count = 8'h00;
    m_held  = 16'h0000;
    m_first = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk1);
      if (!rst && bus.frame_valid !== 1'b0) begin
        n_pulse++;
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got value %h valid %b, expected no frame", bus.value, bus.frame_valid);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("frame_value", 32'(bus.value), 32'(e.v));
          check("frame_err", 32'(bus.frame_err), 32'(e.e));
          check("frame_count", 32'(bus.frame_count), 32'(e.c));
        end
      end
    end
  end

  initial begin
    bus.anodes  = 4'hF;
    bus.cathods = 8'hFF;
    repeat (3) @(negedge clk1);
    rst = 1'b0;
    check("reset_value", 32'(bus.value), 32'h0);
    check("reset_valid", 32'(bus.frame_valid), 32'h0);
    check("reset_err", 32'(bus.frame_err), 32'h0);
    check("reset_count", 32'(bus.frame_count), 32'h0);

    // Clean frame 3210
    expect_frame(16'h3210, 1'b0);
    scan(16'h3210, 8);
    idle(10);

    // Digits held one cycle too short never capture
    scan(16'h3210, 3);
    idle(10);

    // Blank digit 2 gives an error frame, then a clean one
    expect_frame(16'h8088, 1'b1);
    show(0, 8'h80, 8);
    show(1, 8'h80, 8);
    show(2, 8'hFF, 8);
    show(3, 8'h80, 8);
    idle(10);
    expect_frame(16'h8888, 1'b0);
    scan(16'h8888, 8);
    idle(10);

    // Multi-low and blanking anodes between digits are ignored
    expect_frame(16'hC0DE, 1'b0);
    show(0, seg_tb[14], 8);
    show(1, seg_tb[13], 8);
    drive_raw(4'hC, 8'h80, 20);
    drive_raw(4'hF, 8'h80, 20);
    show(2, seg_tb[0], 8);
    show(3, seg_tb[12], 8);
    idle(10);

    // Reset mid-frame drops partial captures
    show(0, seg_tb[7], 8);
    show(1, seg_tb[7], 8);
    pulse_reset();
    check("midreset_value", 32'(bus.value), 32'h0);
    check("midreset_count", 32'(bus.frame_count), 32'h0);
    expect_frame(16'hABCD, 1'b0);
    scan(16'hABCD, 8);
    idle(10);

    // Two identical frames
    pulse_reset();
    expect_frame(16'h1234, 1'b0);
    scan(16'h1234, 8);
    idle(10);
    expect_frame(16'h1234, 1'b0);
    scan(16'h1234, 8);
    idle(20);

    check("pulse_total", 32'(n_pulse), 32'(n_push));
    check("queue_empty", 32'(q.size()), 32'h0);
    check("final_count", 32'(bus.frame_count), 32'(m_count));
    check("final_value", 32'(bus.value), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_frame_decoder.md
Name: seg7_frame_decoder

Overview:
- Receive-side counterpart of the board's multiplexed seven-segment driver.
- Watches the `anodes`/`cathods` scan outputs and rebuilds the 4-digit hex value being displayed.
- Reports each completed frame with a one-cycle strobe.
- Used as a bench monitor and on-chip self-check behind `integratemod`, so the displayed pipeline value (instruction/address/ALU output) can be checked automatically.

Parameters:
- STABLE_CYCLES, 4, cycles an input pattern must hold unchanged before it is captured (legal range 2..255).
- CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk1  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- anodes  in  4  digit enables, active low; anodes[0] = rightmost digit = value[3:0]
- cathods  in  8  segments, active low; [6:0] = g,f,e,d,c,b,a; [7] = dp (ignored)
- value  out  16  last completed frame, digit i in value[4i+3:4i]
- frame_valid  out  1  one-cycle pulse when value/frame_err update
- frame_err  out  1  at least one digit of the last frame had an undecodable pattern
- frame_count  out  8  completed frames, wraps 255->0

Behaviour:
- Reset (synchronous, rst=1 at clk1 edge): value=0, frame_valid=0, frame_err=0, frame_count=0; internal input regs=8'hFF/4'hF, stable counter=0, seen mask=0, error accumulator=0, FSM=SCAN. Reset mid-frame discards all partial captures.
- Input stage: anodes/cathods registered once (anod_q, cath_q); all logic uses the registered copies.
- Stability counter:
  - {anod_q,cath_q} equal to previous cycle: count += 1, saturating at STABLE_CYCLES.
  - Otherwise count = 0.
- Capture strobe: asserted for exactly one cycle, when count transitions to STABLE_CYCLES-1.
- Capture is ignored unless anod_q has exactly one bit low. All-high (blanking) and multi-low patterns never capture.
- On capture of digit i:
  - cath_q[6:0] decoded against the table 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
  - digit_reg[i] = decoded nibble; seen[i] = 1.
  - No table match: digit_reg[i] = 0 and the error accumulator is set.
  - Re-capture of an already-seen digit before frame completion overwrites it; no extra event.
- FSM:
  - SCAN: capture as above. When seen == 4'b1111, go to EMIT.
  - EMIT (one cycle): value = {digit_reg[3..0]}, frame_err = accumulator, frame_valid = 1, frame_count += 1, seen = 0, accumulator = 0; return to SCAN.
  - A capture strobe arriving during EMIT is applied after the clear, so it counts toward the next frame.
- frame_valid is 0 in all other cycles. value and frame_err hold between frames.
- Latency: new steady digit on inputs -> capture at cycle STABLE_CYCLES+1; 4th capture -> frame_valid exactly 2 cycles later (capture edge, EMIT edge).

Optional Feature:
- SEG7_CHANGE_ONLY_EN
- Defined: EMIT raises frame_valid and increments frame_count only if the new value differs from the currently held value, or the new frame_err=1, or this is the first frame since reset. value/frame_err update regardless.
- Undefined: every completed frame pulses frame_valid and counts.

Decomposition:
- Shared package seg7_pkg:
  - segment-pattern constants SEG_0..SEG_F (active-low, 7-bit)
  - FSM state typedef {SCAN, EMIT}
  - function seg_to_nibble(pattern) -> {hit, nibble}
- One natural sub-module: seg7_stable_filter (input register + stability counter + capture strobe), instantiated once.

Test Plan:
- Hold anodes=4'hE cathods=8'hC0, then 4'hD/8'hF9, 4'hB/8'hA4, 4'h7/8'hB0, each 8 cycles -> single frame_valid pulse, value=16'h3210, frame_err=0, frame_count=1.
- Same scan but each digit held only STABLE_CYCLES-1 cycles -> no capture, frame_valid never asserts.
- Digit 2 driven cathods=8'hFF (blank) in a full scan with others 8'h80 -> frame_valid, value=16'h8088, frame_err=1; next clean all-8 frame -> value=16'h8888, frame_err=0.
- anodes=4'hC (two low) or 4'hF held 20 cycles between digits -> ignored; remaining scan completes normally with the correct value.
- rst=1 for one cycle after digits 0,1 captured, then full scan showing 16'hABCD -> value=16'hABCD, frame_count=1, no stale nibbles.
- Two identical scans of 16'h1234: without SEG7_CHANGE_ONLY_EN -> 2 pulses, frame_count=2; with it -> 1 pulse, frame_count=1.
